// File: rtl/qsin_pkg.sv
// qsin_pkg: definitions shared by the quadrature sine/cosine NCO.
//   quad_e        : phase quadrant, taken from the top two phase bits.
//   *_DEF         : default sample width, table address width, phase width
//                   and table full-scale.
package qsin_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  localparam int DW_DEF    = 16;
  localparam int ABITS_DEF = 8;
  localparam int PW_DEF    = 32;
  localparam int SCALE_DEF = 32767;

endpackage

// File: rtl/qsin_quad_map.sv
// qsin_quad_map: combinational quadrant sign/select map.
// A quarter-wave table supplies two terms per phase:
//   T = table[idx]         (sine of the in-quadrant angle)
//   M = table[SIZE - idx]  (cosine of the in-quadrant angle)
// The quadrant then chooses which term each output takes and its sign.
// Ports:
//   q_i   : quadrant of the sample
//   t_i   : direct table term T
//   m_i   : mirrored table term M
//   sin_o : signed sine sample
//   cos_o : signed cosine sample
module qsin_quad_map
  import qsin_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  quad_e                 q_i,
  input  logic signed [DW-1:0]  t_i,
  input  logic signed [DW-1:0]  m_i,
  output logic signed [DW-1:0]  sin_o,
  output logic signed [DW-1:0]  cos_o
);

  // Plain DW-bit two's complement: wraps instead of saturating. Table
  // words never reach the most negative code, so no wrap occurs in use.
  function automatic logic signed [DW-1:0] neg(input logic signed [DW-1:0] x);
    return -x;
  endfunction

  always_comb begin
    sin_o = '0;
    cos_o = '0;
    case (q_i)
      Q0: begin sin_o = t_i;      cos_o = m_i;      end
      Q1: begin sin_o = m_i;      cos_o = neg(t_i); end
      Q2: begin sin_o = neg(t_i); cos_o = neg(m_i); end
      Q3: begin sin_o = neg(m_i); cos_o = t_i;      end
      default: begin sin_o = '0;  cos_o = '0;       end
    endcase
  end

endmodule

// File: rtl/qsin_nco.sv
// qsin_nco: quadrature NCO driving an external quarter-wave sine table.
// A PW-bit phase accumulator is decoded into quadrant + table index; two
// table addresses (direct and mirrored) are driven combinationally, the
// table returns data one cycle later, and the sign/select map produces a
// registered sine/cosine pair.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   en                  : advance phase one step and issue a sample
//   sync_clr            : zero phase, flush in-flight samples
//   inc_load, phase_inc : capture a new phase step
//   lut_addr1/2         : direct / mirrored table addresses
//   lut_data1/2         : table words, one cycle after the addresses
//   sin_out, cos_out    : signed samples (hold between valid samples)
//   out_valid           : new sample present, two cycles after its en
module qsin_nco
  import qsin_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int ABITS = ABITS_DEF,
  parameter int PW    = PW_DEF,
  parameter int SCALE = SCALE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sync_clr,
  input  logic                  inc_load,
  input  logic [PW-1:0]         phase_inc,
  output logic [ABITS-1:0]      lut_addr1,
  output logic [ABITS-1:0]      lut_addr2,
  input  logic signed [DW-1:0]  lut_data1,
  input  logic signed [DW-1:0]  lut_data2,
  output logic signed [DW-1:0]  sin_out,
  output logic signed [DW-1:0]  cos_out,
  output logic                  out_valid
);

  localparam logic signed [DW-1:0] SCALE_W = DW'(SCALE);

  logic [PW-1:0]         phase_q, phase_d;
  logic [PW-1:0]         inc_q, inc_d;
  logic [ABITS-1:0]      idx;
  quad_e                 quad;

  quad_e                 quad_p0_q;
  logic                  idx0_p0_q;
  logic                  vld_p0_q, vld_p0_d;
  logic                  vld_p1_q, vld_p1_d;

  logic signed [DW-1:0]  m_p1;
  logic signed [DW-1:0]  sin_p1, cos_p1;
  logic signed [DW-1:0]  sin_q, sin_d;
  logic signed [DW-1:0]  cos_q, cos_d;

  // ---- stage p0: phase decode, table addressing ----
  assign quad      = quad_e'(phase_q[PW-1 -: 2]);
  assign idx       = phase_q[PW-3 -: ABITS];
  assign lut_addr1 = idx;
  // Mirrored index wraps to 0 at idx==0; that entry is replaced by SCALE
  // downstream since table[SIZE] does not exist.
  assign lut_addr2 = {ABITS{1'b0}} - idx;

  always_comb begin
    phase_d = phase_q;
    if (sync_clr)
      phase_d = '0;
    else if (en)
      phase_d = phase_q + inc_q;
    inc_d    = inc_load ? phase_inc : inc_q;
    vld_p0_d = en & ~sync_clr;
    vld_p1_d = vld_p0_q & ~sync_clr;
  end

  // ---- stage p1: table data aligned with quadrant, output select ----
  assign m_p1 = idx0_p0_q ? SCALE_W : lut_data2;

  qsin_quad_map #(
    .DW (DW)
  ) u_quad_map (
    .q_i   (quad_p0_q),
    .t_i   (lut_data1),
    .m_i   (m_p1),
    .sin_o (sin_p1),
    .cos_o (cos_p1)
  );

  always_comb begin
    sin_d = sin_q;
    cos_d = cos_q;
    if (vld_p1_d) begin
      sin_d = sin_p1;
      cos_d = cos_p1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q   <= '0;
      inc_q     <= '0;
      quad_p0_q <= Q0;
      idx0_p0_q <= 1'b0;
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      sin_q     <= '0;
      cos_q     <= '0;
    end else begin
      phase_q   <= phase_d;
      inc_q     <= inc_d;
      quad_p0_q <= quad;
      idx0_p0_q <= (idx == '0);
      vld_p0_q  <= vld_p0_d;
      vld_p1_q  <= vld_p1_d;
      sin_q     <= sin_d;
      cos_q     <= cos_d;
    end
  end

  // ---- stage p2: registered outputs ----
  assign sin_out   = sin_q;
  assign cos_out   = cos_q;
  assign out_valid = vld_p1_q;

endmodule

// File: tb/tb_qsin_nco.sv
// tb_qsin_nco: self-checking bench for qsin_nco with a registered
// quarter-wave table model and an ideal sin/cos reference.
module tb_qsin_nco;

  localparam int  DW    = 16;
  localparam int  ABITS = 8;
  localparam int  PW    = 32;
  localparam int  SCALE = 32767;
  localparam real PI    = 3.14159265358979323846;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic                  sync_clr;
  logic                  inc_load;
  logic [PW-1:0]         phase_inc;
  logic [ABITS-1:0]      lut_addr1;
  logic [ABITS-1:0]      lut_addr2;
  logic signed [DW-1:0]  lut_data1 = '0;
  logic signed [DW-1:0]  lut_data2 = '0;
  logic signed [DW-1:0]  sin_out;
  logic signed [DW-1:0]  cos_out;
  logic                  out_valid;

  qsin_nco #(
    .DW    (DW),
    .ABITS (ABITS),
    .PW    (PW),
    .SCALE (SCALE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync_clr  (sync_clr),
    .inc_load  (inc_load),
    .phase_inc (phase_inc),
    .lut_addr1 (lut_addr1),
    .lut_addr2 (lut_addr2),
    .lut_data1 (lut_data1),
    .lut_data2 (lut_data2),
    .sin_out   (sin_out),
    .cos_out   (cos_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Ideal reference: full-circle angle from the top 10 phase bits.
  function automatic int ideal_sin(input logic [PW-1:0] ph);
    int k;
    k = int'(ph[PW-1 -: ABITS+2]);
    return rnd(32767.0 * $sin(2.0 * PI * real'(k) / 1024.0));
  endfunction

  function automatic int ideal_cos(input logic [PW-1:0] ph);
    int k;
    k = int'(ph[PW-1 -: ABITS+2]);
    return rnd(32767.0 * $cos(2.0 * PI * real'(k) / 1024.0));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_samp(input string name, input int s, input int c);
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_sin"}, int'(sin_out), s);
    check({name, "_cos"}, int'(cos_out), c);
  endtask

  // Quarter-wave table, one cycle read latency.
  int rom [256];
  always @(posedge clk) begin
    lut_data1 <= DW'(rom[lut_addr1]);
    lut_data2 <= DW'(rom[lut_addr2]);
  end

  // Behavioural model: each en cycle schedules the ideal sample of the
  // current phase to appear after the next edge; sync_clr and reset drop
  // everything scheduled.
  typedef struct {
    int due;
    int s;
    int c;
  } samp_t;

  samp_t         pend[$];
  samp_t         e_tmp;
  logic [PW-1:0] m_phase = '0;
  logic [PW-1:0] m_inc   = '0;
  int            m_sin   = 0;
  int            m_cos   = 0;
  bit            m_valid = 1'b0;
  int            cyc     = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_phase = '0;
      m_inc   = '0;
      pend.delete();
      m_sin   = 0;
      m_cos   = 0;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (sync_clr) begin
        pend.delete();
        m_phase = '0;
      end else begin
        if (pend.size() > 0 && pend[0].due == cyc) begin
          e_tmp   = pend.pop_front();
          m_valid = 1'b1;
          m_sin   = e_tmp.s;
          m_cos   = e_tmp.c;
        end
        if (en) begin
          pend.push_back('{cyc + 1, ideal_sin(m_phase), ideal_cos(m_phase)});
          m_phase = m_phase + m_inc;
        end
      end
      if (inc_load) m_inc = phase_inc;
    end
    #1;
    check("mdl_valid", int'(out_valid), int'(m_valid));
    check("mdl_sin", int'(sin_out), m_sin);
    check("mdl_cos", int'(cos_out), m_cos);
  end

  int exp_s [5] = '{0, 32767, 0, -32767, 0};
  int exp_c [5] = '{32767, 0, -32767, 0, 32767};
  int vcnt;
  int vfirst;

  initial begin
    for (int i = 0; i < 256; i++)
      rom[i] = rnd(32767.0 * $sin(2.0 * PI * real'(i) / 1024.0));
    rst = 1'b0; en = 1'b0; sync_clr = 1'b0; inc_load = 1'b0; phase_inc = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sin", int'(sin_out), 0);
    check("rst_cos", int'(cos_out), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_addr1", int'(lut_addr1), 0);
    check("rst_addr2", int'(lut_addr2), 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_valid", int'(out_valid), 0);

    // Quarter-turn step, continuous en
    inc_load = 1'b1; phase_inc = 32'h4000_0000;
    @(negedge clk);
    inc_load = 1'b0; en = 1'b1;
    @(negedge clk);
    check("lat_early_valid", int'(out_valid), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_samp($sformatf("quarter%0d", i), exp_s[i], exp_c[i]);
    end
    en = 1'b0;
    @(negedge clk);
    chk_samp("quarter_tail", 32767, 0);
    @(negedge clk);
    check("idle_valid", int'(out_valid), 0);
    check("idle_hold_sin", int'(sin_out), 32767);

    // Single en pulse
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    vcnt = 0; vfirst = -1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) begin
        vcnt++;
        if (vfirst < 0) vfirst = i;
      end
      @(negedge clk);
    end
    check("pulse_count", vcnt, 1);
    check("pulse_lat", vfirst, 1);

    // Phase wrap backwards: step of -1 LSB from phase 0
    sync_clr = 1'b1; inc_load = 1'b1; phase_inc = 32'hFFFF_FFFF;
    @(negedge clk);
    sync_clr = 1'b0; inc_load = 1'b0; en = 1'b1;
    @(negedge clk);
    check("wrap_addr1", int'(lut_addr1), 255);
    check("wrap_addr2", int'(lut_addr2), 1);
    @(negedge clk);
    en = 1'b0;
    chk_samp("wrap0", 0, 32767);
    @(negedge clk);
    chk_samp("wrap1", -201, 32766);

    // sync_clr together with en mid-run
    inc_load = 1'b1; phase_inc = 32'h4000_0000;
    @(negedge clk);
    inc_load = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0; en = 1'b0;
    check("clr_valid1", int'(out_valid), 0);
    check("clr_addr1", int'(lut_addr1), 0);
    @(negedge clk);
    check("clr_valid2", int'(out_valid), 0);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk_samp("clr_next", 0, 32767);

    // inc_load mid-stream, then reset mid-stream
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0; en = 1'b1;
    @(negedge clk);
    inc_load = 1'b1; phase_inc = 32'h8000_0000;
    @(negedge clk);
    inc_load = 1'b0;
    chk_samp("inc0", 0, 32767);
    @(negedge clk);
    chk_samp("inc1", 32767, 0);
    @(negedge clk);
    chk_samp("inc2", 0, -32767);
    @(negedge clk);
    chk_samp("inc3", 0, 32767);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_sin", int'(sin_out), 0);
    check("arst_cos", int'(cos_out), 0);
    check("arst_addr1", int'(lut_addr1), 0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_stale", int'(out_valid), 0);
    end

    // Mixed traffic against the model
    for (int i = 0; i < 300; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      sync_clr  = ($urandom_range(0, 15) == 0);
      inc_load  = ($urandom_range(0, 7) == 0);
      phase_inc = $urandom();
      @(negedge clk);
    end
    en = 1'b0; sync_clr = 1'b0; inc_load = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
